native2axis: RTL and testbench
==============================

NATIVE2AXIS -- requirements
Module: native2axis

Interface
REQ-001 SHALL have parameter DATA_WID, default 24, pixel width in bits (multiple of 8).
REQ-002 SHALL have parameter FIFO_AW, default 10, FIFO address width; depth = 2**FIFO_AW entries.
REQ-003 SHALL have port clk  input  1  single clock for native and AXIS sides.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port en  input  1  capture enable, sampled at frame boundary.
REQ-006 SHALL have port ovf_clr  input  1  one-cycle pulse, clears ovf.
REQ-007 SHALL have port natv_active  input  1  native active-video qualifier.
REQ-008 SHALL have port natv_vsync  input  1  native vsync, active-high.
REQ-009 SHALL have port natv_data  input  DATA_WID  native pixel.
REQ-010 SHALL have port axis_tdata  output  DATA_WID  stream pixel.
REQ-011 SHALL have port axis_tkeep  output  DATA_WID/8  byte enables.
REQ-012 SHALL have ports axis_tvalid, axis_tuser, axis_tlast  output  1 each; axis_tready  input  1.
REQ-013 SHALL have port ovf  output  1  sticky FIFO overflow flag.
REQ-014 SHALL have ports ppl_meas, lpf_meas  output  12 each  measured active pixels/line, active lines/frame.

Function
REQ-015 SHALL implement states IDLE, WAIT_SOF, RUN, DROP; frame boundary = rising edge of natv_vsync (vs_rise).
REQ-016 SHALL transition IDLE->WAIT_SOF on vs_rise with en=1; WAIT_SOF->RUN on first natv_active=1 cycle; RUN->IDLE on vs_rise with en=0; RUN->DROP on write attempt while FIFO full; DROP->WAIT_SOF on vs_rise with en=1, DROP->IDLE on vs_rise with en=0.
REQ-017 SHALL register each active pixel one cycle (write pipeline) and push {tuser,tlast,data} into the FIFO only in RUN (including the WAIT_SOF->RUN pixel).
REQ-018 SHALL set tuser on the first pushed pixel after entering RUN from WAIT_SOF, zero otherwise.
REQ-019 SHALL set tlast on a pixel whose following cycle has natv_active=0, or on a pixel coinciding with vs_rise.
REQ-020 SHALL provide first-word-fall-through output: axis_tvalid = FIFO not empty; entry popped when axis_tvalid and axis_tready both 1.
REQ-021 SHALL hold axis_tdata/tuser/tlast stable while axis_tvalid=1 and axis_tready=0.
REQ-022 SHALL give latency of 2 cycles from native pixel input to earliest axis_tvalid with empty FIFO and tready=1.
REQ-023 SHALL drive axis_tkeep all ones constantly.
REQ-024 SHALL treat simultaneous push and pop on a full FIFO as non-overflow (pop frees the slot); on empty FIFO as pass-through with count unchanged.
REQ-025 SHALL set ovf=1 on a dropped write; ovf_clr clears it unless an overflow occurs the same cycle (set wins).
REQ-026 SHALL discard all pixels in DROP; FIFO contents already stored SHALL still drain.
REQ-027 SHALL count active pixels per line (saturate at 4095) and lines containing active pixels per frame (saturate 4095), independent of state; ppl_meas latched at each line end, lpf_meas latched at vs_rise then counter cleared.
REQ-028 SHALL wrap FIFO read/write pointers modulo depth, using an extra MSB for full/empty distinction.

Reset
REQ-029 SHALL on rstn=0 asynchronously: state IDLE, FIFO empty, axis_tvalid=0, axis_tuser=0, axis_tlast=0, ovf=0, ppl_meas=0, lpf_meas=0, counters 0, pipeline register cleared.
REQ-030 SHALL, on reset mid-frame, after release wait in IDLE for next vs_rise; no partial frame emitted.

Verification
REQ-031 SHALL cover: en=1, 8x4 active frame, tready=1 -> 32 beats, tuser on beat 0 only, tlast on beats 7/15/23/31, ppl_meas=8, lpf_meas=4 after next vs_rise.
REQ-032 SHALL cover: same frame, tready toggling 1/0 every cycle, FIFO_AW=4 -> identical 32-beat sequence, ovf=0, no data change while stalled.
REQ-033 SHALL cover: FIFO_AW=4, tready=0 whole frame -> 16 entries stored, ovf=1, state DROP; tready=1 -> 16 beats drain; next frame captured fully with tuser; ovf_clr -> ovf=0.
REQ-034 SHALL cover: en deasserted mid-frame -> current frame completes all 32 beats, next frame produces no beats.
REQ-035 SHALL cover: rstn pulsed low at pixel 13 of frame -> outputs at reset values immediately, zero beats until the following frame, which arrives with tuser on beat 0.
REQ-036 SHALL cover: ovf_clr asserted same cycle as overflow write -> ovf remains 1.

Source files
------------

// File: rtl/native2axis.sv
// Native video (active/vsync/data) to AXI4-Stream bridge with frame-aligned
// capture, a first-word-fall-through FIFO and line/frame size measurement.
module native2axis #(
  parameter int unsigned DATA_WID = 24,
  parameter int unsigned FIFO_AW  = 10
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  en,
  input  logic                  ovf_clr,
  input  logic                  natv_active,
  input  logic                  natv_vsync,
  input  logic [DATA_WID-1:0]   natv_data,
  output logic [DATA_WID-1:0]   axis_tdata,
  output logic [DATA_WID/8-1:0] axis_tkeep,
  output logic                  axis_tvalid,
  output logic                  axis_tuser,
  output logic                  axis_tlast,
  input  logic                  axis_tready,
  output logic                  ovf,
  output logic [11:0]           ppl_meas,
  output logic [11:0]           lpf_meas
);

  localparam int unsigned KEEP_WID = DATA_WID / 8;
  localparam int unsigned ENT_WID  = DATA_WID + 2;
  localparam int unsigned PTR_WID  = FIFO_AW + 1;
  localparam int unsigned DEPTH    = 2 ** FIFO_AW;
  localparam int unsigned CNT_WID  = 12;
  localparam logic [CNT_WID-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, WAIT_SOF, RUN, DROP} state_t;

  state_t               state;
  state_t               state_nxt;
  logic                 vs_prev;
  logic                 act_prev;
  logic                 vs_rise;
  logic                 line_start;
  logic                 line_end;
  logic                 pipe_valid;
  logic                 pipe_user;
  logic                 pipe_vs;
  logic [DATA_WID-1:0]  pipe_data;
  logic [PTR_WID-1:0]   wptr;
  logic [PTR_WID-1:0]   rptr;
  logic [PTR_WID-1:0]   wptr_nxt;
  logic [PTR_WID-1:0]   rptr_nxt;
  logic                 full;
  logic                 push;
  logic                 pop;
  logic                 push_ok;
  logic                 drop;
  logic                 nonempty_nxt;
  logic                 bypass;
  logic [ENT_WID-1:0]   push_word;
  logic [ENT_WID-1:0]   head_word;
  logic [ENT_WID-1:0]   mem [DEPTH];
  logic [CNT_WID-1:0]   pix_cnt;
  logic [CNT_WID-1:0]   line_cnt;

  assign axis_tkeep = {KEEP_WID{1'b1}};

  assign vs_rise    = natv_vsync & ~vs_prev;
  assign line_start = natv_active & ~act_prev;
  assign line_end   = ~natv_active & act_prev;

  // A pixel's tlast is only known one cycle later, so the pipelined pixel is
  // pushed with the current cycle's active qualifier folded in.
  assign push      = pipe_valid && (state == RUN);
  assign push_word = {pipe_user, pipe_vs | ~natv_active, pipe_data};
  assign pop       = axis_tvalid & axis_tready;
  assign full      = (wptr[FIFO_AW] != rptr[FIFO_AW]) &&
                     (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);
  assign push_ok   = push & (~full | pop);
  assign drop      = push & full & ~pop;
  assign wptr_nxt  = push_ok ? wptr + PTR_WID'(1) : wptr;
  assign rptr_nxt  = pop ? rptr + PTR_WID'(1) : rptr;
  assign nonempty_nxt = (wptr_nxt != rptr_nxt);
  // The word being written becomes the new head only when it lands in the
  // slot the read pointer will point at next.
  assign bypass    = push_ok && (wptr[FIFO_AW-1:0] == rptr_nxt[FIFO_AW-1:0]);
  assign head_word = bypass ? push_word : mem[rptr_nxt[FIFO_AW-1:0]];

  // Capture state transitions
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (vs_rise && en) state_nxt = WAIT_SOF;
      WAIT_SOF: if (natv_active) state_nxt = RUN;
      RUN: begin
        if (vs_rise && !en) state_nxt = IDLE;
        else if (drop)      state_nxt = DROP;
      end
      DROP:     if (vs_rise) state_nxt = en ? WAIT_SOF : IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Edge-detect history for vsync and active
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vs_prev  <= 1'b0;
      act_prev <= 1'b0;
    end else begin
      vs_prev  <= natv_vsync;
      act_prev <= natv_active;
    end
  end

  // Write pipeline: hold one pixel while its tlast is resolved
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pipe_valid <= 1'b0;
      pipe_user  <= 1'b0;
      pipe_vs    <= 1'b0;
      pipe_data  <= '0;
    end else begin
      pipe_valid <= natv_active && ((state == WAIT_SOF) || (state == RUN));
      pipe_user  <= (state == WAIT_SOF);
      pipe_vs    <= vs_rise;
      pipe_data  <= natv_data;
    end
  end

  // FIFO pointers and registered fall-through head
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr        <= '0;
      rptr        <= '0;
      axis_tvalid <= 1'b0;
      axis_tuser  <= 1'b0;
      axis_tlast  <= 1'b0;
      axis_tdata  <= '0;
    end else begin
      wptr        <= wptr_nxt;
      rptr        <= rptr_nxt;
      axis_tvalid <= nonempty_nxt;
      if (nonempty_nxt) {axis_tuser, axis_tlast, axis_tdata} <= head_word;
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[FIFO_AW-1:0]] <= push_word;
  end

  // Sticky overflow flag; a new drop beats a simultaneous clear
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)        ovf <= 1'b0;
    else if (drop)    ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end

  // Pixels-per-line and lines-per-frame measurement, independent of capture
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pix_cnt  <= '0;
      line_cnt <= '0;
      ppl_meas <= '0;
      lpf_meas <= '0;
    end else begin
      if (line_end) begin
        ppl_meas <= pix_cnt;
        pix_cnt  <= '0;
      end else if (natv_active && (pix_cnt != CNT_MAX)) begin
        pix_cnt <= pix_cnt + CNT_WID'(1);
      end
      if (vs_rise) begin
        lpf_meas <= line_cnt;
        line_cnt <= line_start ? CNT_WID'(1) : '0;
      end else if (line_start && (line_cnt != CNT_MAX)) begin
        line_cnt <= line_cnt + CNT_WID'(1);
      end
    end
  end

endmodule

// File: tb/tb_native2axis.sv
// Bench for native2axis: frame-level scoreboard of expected stream beats,
// a per-cycle compare process, and literal spot checks.
module tb_native2axis;

  localparam int unsigned DW = 24;
  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          en = 1'b0;
  logic          ovf_clr = 1'b0;
  logic          natv_active = 1'b0;
  logic          natv_vsync = 1'b0;
  logic [DW-1:0] natv_data = '0;
  logic [DW-1:0] axis_tdata;
  logic [2:0]    axis_tkeep;
  logic          axis_tvalid;
  logic          axis_tuser;
  logic          axis_tlast;
  logic          axis_tready = 1'b1;
  logic          ovf;
  logic [11:0]   ppl_meas;
  logic [11:0]   lpf_meas;

  native2axis #(.DATA_WID(DW), .FIFO_AW(AW)) dut (
    .clk(clk), .rstn(rstn), .en(en), .ovf_clr(ovf_clr),
    .natv_active(natv_active), .natv_vsync(natv_vsync), .natv_data(natv_data),
    .axis_tdata(axis_tdata), .axis_tkeep(axis_tkeep), .axis_tvalid(axis_tvalid),
    .axis_tuser(axis_tuser), .axis_tlast(axis_tlast), .axis_tready(axis_tready),
    .ovf(ovf), .ppl_meas(ppl_meas), .lpf_meas(lpf_meas)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int tr_mode = 1;          // 0: ready low, 1: ready high, 2: toggle each cycle
  int fid = 0;
  int beats = 0;
  int sof_cyc = 0;
  int rise_cyc = -1;
  bit lat_arm = 1'b0;
  bit m_cap = 1'b0;         // frame pixels are expected to reach the stream
  bit m_sof = 1'b0;         // next stored pixel carries tuser
  bit stall_prev = 1'b0;
  bit tv_prev = 1'b0;
  logic [25:0] held;
  logic [25:0] cur;
  logic [25:0] exp_d;
  logic [25:0] exp_q[$];
  logic [25:0] log_q[$];

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_chk++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, expv);
    end
  endtask

  task automatic chk_log(input string name, input int idx, input logic [25:0] expv);
    if (idx < log_q.size()) chk(name, 32'(log_q[idx]), 32'(expv));
    else begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: beat %0d missing, expected %0h", name, idx, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Ready pattern generator
  initial forever begin
    @(posedge clk);
    #1;
    case (tr_mode)
      0:       axis_tready = 1'b0;
      1:       axis_tready = 1'b1;
      default: axis_tready = ~axis_tready;
    endcase
  end

  // Per-cycle output check against the scoreboard
  always @(negedge clk) begin
    cur = {axis_tuser, axis_tlast, axis_tdata};
    if (!rstn) begin
      stall_prev = 1'b0;
      tv_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall tvalid", 32'(axis_tvalid), 1);
        chk("stall hold", 32'(cur), 32'(held));
      end
      if (lat_arm && axis_tvalid && !tv_prev) begin
        rise_cyc = cyc;
        lat_arm = 1'b0;
      end
      if (axis_tvalid && axis_tready) begin
        chk("tkeep", 32'(axis_tkeep), 32'h7);
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected beat: got %0h, expected none", cur);
        end else begin
          exp_d = exp_q.pop_front();
          chk("beat", 32'(cur), 32'(exp_d));
        end
        log_q.push_back(cur);
        beats++;
      end
      stall_prev = axis_tvalid && !axis_tready;
      held = cur;
      tv_prev = axis_tvalid;
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " tvalid"}, 32'(axis_tvalid), 0);
    chk({tag, " tuser"},  32'(axis_tuser), 0);
    chk({tag, " tlast"},  32'(axis_tlast), 0);
    chk({tag, " ovf"},    32'(ovf), 0);
    chk({tag, " ppl"},    32'(ppl_meas), 0);
    chk({tag, " lpf"},    32'(lpf_meas), 0);
  endtask

  // Vsync pulse; applies the frame-boundary capture rule to the model
  task automatic vsync_pulse();
    natv_active = 1'b0;
    natv_vsync = 1'b1;
    if (en) begin
      if (!m_cap) begin
        m_cap = 1'b1;
        m_sof = 1'b1;
      end
    end else m_cap = 1'b0;
    step();
    step();
    natv_vsync = 1'b0;
    repeat (3) step();
  endtask

  // 8x4 active frame; pixel index hooks for en drop, reset and ovf_clr
  task automatic lines(input int n_store, input int en_off_pix, input int rst_pix, input int clr_pix);
    int pix = 0;
    fid++;
    for (int l = 0; l < 4; l++) begin
      for (int c = 0; c < 8; c++) begin
        rstn = 1'b1;
        natv_active = 1'b1;
        natv_data = {8'(fid), 8'(l), 8'(c)};
        ovf_clr = (pix == clr_pix);
        if (pix == en_off_pix) en = 1'b0;
        if (pix == 0) sof_cyc = cyc;
        if (pix == rst_pix) begin
          rstn = 1'b0;
          exp_q.delete();
          m_cap = 1'b0;
          m_sof = 1'b0;
          #1;
          chk_reset_outputs("midframe reset");
        end else if (m_cap) begin
          if (pix < n_store) begin
            exp_q.push_back({m_sof, (c == 7), natv_data});
            m_sof = 1'b0;
          end else m_cap = 1'b0;
        end
        pix++;
        step();
      end
      natv_active = 1'b0;
      ovf_clr = 1'b0;
      rstn = 1'b1;
      repeat (4) step();
    end
    repeat (4) step();
  endtask

  task automatic wait_drain();
    int i;
    for (i = 0; i < 300; i++) begin
      if (exp_q.size() == 0 && !axis_tvalid) break;
      step();
    end
    chk("drain timeout", 32'(i >= 300), 0);
  endtask

  task automatic pulse_clr();
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rstn = 1'b1;
    step();

    // Basic frame, ready always high
    en = 1'b1;
    tr_mode = 1;
    vsync_pulse();
    b0 = beats;
    lat_arm = 1'b1;
    lines(32, -1, -1, -1);
    wait_drain();
    chk("t1 beats", 32'(beats - b0), 32);
    chk("t1 latency", 32'(rise_cyc - sof_cyc), 2);
    chk_log("t1 beat0", b0, {1'b1, 1'b0, 24'h010000});
    chk_log("t1 beat7", b0 + 7, {1'b0, 1'b1, 24'h010007});
    chk_log("t1 beat8", b0 + 8, {1'b0, 1'b0, 24'h010100});
    chk_log("t1 beat31", b0 + 31, {1'b0, 1'b1, 24'h010307});
    chk("t1 ppl", 32'(ppl_meas), 8);
    chk("t1 lpf before next vsync", 32'(lpf_meas), 0);

    // Disabled frame: no beats, line count latched
    en = 1'b0;
    vsync_pulse();
    chk("lpf after frame", 32'(lpf_meas), 4);
    b0 = beats;
    lines(32, -1, -1, -1);
    wait_drain();
    chk("disabled frame beats", 32'(beats - b0), 0);

    // Ready toggling every cycle
    en = 1'b1;
    tr_mode = 2;
    vsync_pulse();
    b0 = beats;
    lines(32, -1, -1, -1);
    wait_drain();
    tr_mode = 1;
    chk("t2 beats", 32'(beats - b0), 32);
    chk_log("t2 beat0", b0, {1'b1, 1'b0, 24'h030000});
    chk_log("t2 beat15", b0 + 15, {1'b0, 1'b1, 24'h030107});
    chk("t2 ovf", 32'(ovf), 0);

    // Ready low for a whole frame: 16 stored, overflow, drop
    tr_mode = 0;
    step();
    step();
    vsync_pulse();
    b0 = beats;
    lines(16, -1, -1, -1);
    chk("t3 beats while stalled", 32'(beats - b0), 0);
    chk("t3 ovf", 32'(ovf), 1);
    chk("t3 tvalid", 32'(axis_tvalid), 1);
    tr_mode = 1;
    wait_drain();
    chk("t3 drained beats", 32'(beats - b0), 16);
    chk_log("t3 beat0", b0, {1'b0, 1'b0, 24'h040000});
    chk_log("t3 beat15", b0 + 15, {1'b0, 1'b1, 24'h040107});
    vsync_pulse();
    b0 = beats;
    lines(32, -1, -1, -1);
    wait_drain();
    chk("t3 recovery beats", 32'(beats - b0), 32);
    chk_log("t3 recovery beat0", b0, {1'b1, 1'b0, 24'h050000});
    chk("t3 ovf sticky", 32'(ovf), 1);
    pulse_clr();
    chk("t3 ovf cleared", 32'(ovf), 0);

    // en dropped mid-frame: frame completes, next frame ignored
    vsync_pulse();
    b0 = beats;
    lines(32, 16, -1, -1);
    wait_drain();
    chk("t4 beats", 32'(beats - b0), 32);
    chk_log("t4 beat0", b0, {1'b0, 1'b0, 24'h060000});
    vsync_pulse();
    b0 = beats;
    lines(32, -1, -1, -1);
    wait_drain();
    chk("t4 next frame beats", 32'(beats - b0), 0);

    // Reset pulse at pixel 13
    en = 1'b1;
    vsync_pulse();
    b0 = beats;
    lines(32, -1, 13, -1);
    wait_drain();
    chk("t5 beats before reset", 32'(beats - b0), 11);
    vsync_pulse();
    b0 = beats;
    lines(32, -1, -1, -1);
    wait_drain();
    chk("t5 next frame beats", 32'(beats - b0), 32);
    chk_log("t5 beat0", b0, {1'b1, 1'b0, 24'h090000});
    chk_log("t5 beat31", b0 + 31, {1'b0, 1'b1, 24'h090307});

    // ovf_clr in the same cycle as the overflowing write
    tr_mode = 0;
    step();
    step();
    vsync_pulse();
    b0 = beats;
    lines(16, -1, -1, 17);
    chk("t6 ovf set wins", 32'(ovf), 1);
    tr_mode = 1;
    wait_drain();
    chk("t6 drained beats", 32'(beats - b0), 16);
    pulse_clr();
    chk("t6 ovf cleared", 32'(ovf), 0);

    chk("scoreboard empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
